div_iter: RTL and testbench

Iterative radix-2 restoring divider for the execute stage. It sits beside the ALU adder and feeds the execute result mux: it accepts one divide request, produces one bit of quotient per cycle using a single (DATA_LEN+1)-bit subtract-with-borrow, then holds the result until the consumer takes it. It implements the RISC-V M-extension semantics for DIV, DIVU, REM and REMU, including the divide-by-zero and signed-overflow cases.

---
 rtl/div_iter.sv | 207 ++++++++++++++++++++
 tb/tb_div_iter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// div_iter -- iterative radix-2 restoring divider for the execute stage.
//
// The divider accepts one request while idle. It then produces one quotient
// bit per cycle with a single (DATA_LEN+1)-bit subtract-with-borrow, and holds
// the result until the consumer takes it. It follows the RISC-V M-extension
// semantics for DIV, DIVU, REM and REMU, including divide-by-zero and signed
// overflow.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    request valid
//   in_ready    request can be accepted (high only while idle)
//   div_signed  1 = DIV/REM, 0 = DIVU/REMU
//   rem_sel     1 = return remainder, 0 = return quotient
//   dividend    dividend operand (sampled only at acceptance)
//   divisor     divisor operand (sampled only at acceptance)
//   flush       abort whatever is in progress; highest priority
//   out_valid   result valid
//   out_ready   consumer accepts the result
//   result      quotient or remainder
module div_iter #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                div_signed,
  input  logic                rem_sel,
  input  logic [DATA_LEN-1:0] dividend,
  input  logic [DATA_LEN-1:0] divisor,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] result
);

  localparam int CNT_W = $clog2(DATA_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [DATA_LEN-1:0] rem_reg;       // partial remainder
  logic [DATA_LEN-1:0] quo_reg;       // working quotient / shifted dividend
  logic [DATA_LEN-1:0] dvs_reg;       // |divisor|
  logic                signed_reg;
  logic                rem_sel_reg;
  logic                quo_neg_reg;
  logic                rem_neg_reg;
  logic                in_ready_reg;
  logic                out_valid_reg;
  logic [DATA_LEN-1:0] result_reg;

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign result    = result_reg;

  // ---------------------------------------------------------------------
  // Request decode: operand magnitudes and special cases
  // ---------------------------------------------------------------------
  logic                dvd_neg;
  logic                dvs_neg;
  logic [DATA_LEN-1:0] dvd_abs;
  logic [DATA_LEN-1:0] dvs_abs;
  logic                div_zero;
  logic                sig_ovf;
  logic                accept;

  assign dvd_neg  = div_signed & dividend[DATA_LEN-1];
  assign dvs_neg  = div_signed & divisor[DATA_LEN-1];
  // For the most negative value the negation wraps back to itself. Read as
  // unsigned, that is still the correct magnitude.
  assign dvd_abs  = dvd_neg ? -dividend : dividend;
  assign dvs_abs  = dvs_neg ? -divisor  : divisor;
  assign div_zero = (divisor == '0);
  assign sig_ovf  = div_signed
                  && (dividend == {1'b1, {(DATA_LEN-1){1'b0}}})
                  && (divisor == '1);
  // in_ready_reg is high exactly while the state is IDLE.
  assign accept   = in_valid & in_ready_reg & ~flush;

  // ---------------------------------------------------------------------
  // One restoring step
  // ---------------------------------------------------------------------
  // The shifted remainder carries one extra bit. Because rem < |divisor|
  // <= 2^DATA_LEN-1, the shift can overflow DATA_LEN bits. With the extra
  // bit, the top bit of the (DATA_LEN+1)-bit difference is a true borrow.
  logic [DATA_LEN:0]   rem_sh;
  logic [DATA_LEN:0]   trial;
  logic                no_borrow;
  logic [DATA_LEN-1:0] rem_step;
  logic [DATA_LEN-1:0] quo_step;

  assign rem_sh    = {rem_reg, quo_reg[DATA_LEN-1]};
  assign trial     = rem_sh - {1'b0, dvs_reg};
  assign no_borrow = ~trial[DATA_LEN];
  assign rem_step  = no_borrow ? trial[DATA_LEN-1:0] : rem_sh[DATA_LEN-1:0];
  assign quo_step  = {quo_reg[DATA_LEN-2:0], no_borrow};

  // ---------------------------------------------------------------------
  // Sign fix-up applied when the result is published
  // ---------------------------------------------------------------------
  logic [DATA_LEN-1:0] quo_fix;
  logic [DATA_LEN-1:0] rem_fix;
  logic [DATA_LEN-1:0] fin_val;

  assign quo_fix = (signed_reg & quo_neg_reg) ? -quo_reg : quo_reg;
  assign rem_fix = (signed_reg & rem_neg_reg) ? -rem_reg : rem_reg;
  assign fin_val = rem_sel_reg ? rem_fix : quo_fix;

  // ---------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------
  // DONE is split into two phases. With out_valid low, the DONE cycle
  // publishes the result. This gives the DATA_LEN+1 latency for normal
  // requests and 1 for special cases. With out_valid high, DONE waits
  // for the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dvs_reg       <= '0;
      signed_reg    <= 1'b0;
      rem_sel_reg   <= 1'b0;
      quo_neg_reg   <= 1'b0;
      rem_neg_reg   <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
    end else if (flush) begin
      // Abort from any state. result keeps its last value.
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            signed_reg   <= div_signed;
            rem_sel_reg  <= rem_sel;
            in_ready_reg <= 1'b0;
            if (div_zero) begin
              // Results come from the raw operands; no sign fix-up.
              quo_reg     <= '1;
              rem_reg     <= dividend;
              quo_neg_reg <= 1'b0;
              rem_neg_reg <= 1'b0;
              cnt_reg     <= '0;
              state_reg   <= DONE;
            end else if (sig_ovf) begin
              quo_reg     <= dividend;
              rem_reg     <= '0;
              quo_neg_reg <= 1'b0;
              rem_neg_reg <= 1'b0;
              cnt_reg     <= '0;
              state_reg   <= DONE;
            end else begin
              quo_reg     <= dvd_abs;
              rem_reg     <= '0;
              dvs_reg     <= dvs_abs;
              quo_neg_reg <= dvd_neg ^ dvs_neg;
              rem_neg_reg <= dvd_neg;
              cnt_reg     <= CNT_W'(DATA_LEN);
              state_reg   <= CALC;
            end
          end
        end

        CALC: begin
          rem_reg <= rem_step;
          quo_reg <= quo_step;
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= DONE;
          end
        end

        DONE: begin
          if (!out_valid_reg) begin
            result_reg    <= fin_val;
            out_valid_reg <= 1'b1;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter (DATA_LEN = 32).
// Expected results are pushed to a scoreboard queue when a request is driven.
// They are popped and compared when the divider presents its output.
module tb_div_iter;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         div_signed;
  logic         rem_sel;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  div_iter #(.DATA_LEN(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .div_signed(div_signed),
    .rem_sel   (rem_sel),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference model in plain integer arithmetic.
  function automatic logic [W-1:0] model(input bit sg, input bit rs,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    if (b == 0) return rs ? a : 32'hFFFF_FFFF;
    if (!sg) return rs ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rs ? 32'd0 : a;
    sa = a;
    sb = b;
    return rs ? W'(sa % sb) : W'(sa / sb);
  endfunction

  function automatic int model_lat(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return 1;
    if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return W + 1;
  endfunction

  // Mutual exclusion of in_ready and out_valid, sampled every cycle.
  always @(negedge clk) begin
    if (rst_n) check_val("ready_valid_excl", {63'd0, in_ready & out_valid}, 64'd0);
  end

  // Wait for in_ready, present a request, and return just after the
  // accepting edge with the operand inputs scrambled.
  task automatic start_op(input bit sg, input bit rs, input logic [W-1:0] a, input logic [W-1:0] b);
    int k = 0;
    while (!in_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check_val("in_ready_wait", {63'd0, in_ready}, 64'd1);
    div_signed = sg;
    rem_sel    = rs;
    dividend   = a;
    divisor    = b;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    div_signed = ~sg;
    rem_sel    = ~rs;
    dividend   = $urandom;
    divisor    = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      check_val("out_valid_timeout", 64'd0, 64'd1);
      lat = -1;
    end
  endtask

  task automatic run_op(input bit sg, input bit rs, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    int lat;
    logic [W-1:0] exp;
    logic [W-1:0] held;
    start_op(sg, rs, a, b);
    exp_q.push_back(model(sg, rs, a, b));
    wait_valid(lat);
    check_val("latency", 64'(lat), 64'(model_lat(sg, a, b)));
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_val("hold_result", {32'd0, result}, {32'd0, held});
      check_val("hold_valid", {63'd0, out_valid}, 64'd1);
      check_val("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    exp = exp_q.pop_front();
    check_val("result", {32'd0, result}, {32'd0, exp});
    $display("op sg=%0d rem=%0d a=%h b=%h -> result=%h exp=%h lat=%0d",
             sg, rs, a, b, result, exp, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("post_in_ready", {63'd0, in_ready}, 64'd1);
    check_val("post_out_valid", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    int lat;
    bit sg;
    bit rs;
    logic [W-1:0] a;
    logic [W-1:0] b;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    div_signed = 1'b0;
    rem_sel    = 1'b0;
    dividend   = '0;
    divisor    = '0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_result", {32'd0, result}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(0, 0, 32'd100, 32'd7, 0);
    run_op(0, 1, 32'd100, 32'd7, 0);
    run_op(1, 0, -32'sd7, 32'd2, 0);
    run_op(1, 1, -32'sd7, 32'd2, 0);
    run_op(1, 1, 32'd7, -32'sd2, 0);
    run_op(0, 0, 32'h1234_5678, 32'd0, 0);
    run_op(1, 1, 32'h1234_5678, 32'd0, 0);
    run_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);

    // Backpressure
    run_op(0, 0, 32'd1000, 32'd10, 10);

    // Random mix
    for (int i = 0; i < 24; i++) begin
      sg = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      a  = $urandom;
      case (i % 6)
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if (i % 8 == 7) a = 32'h8000_0000;
      run_op(sg, rs, a, b, 0);
    end

    // A request during flush while idle must not be accepted
    flush    = 1'b1;
    in_valid = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check_val("flush_idle_no_accept", {63'd0, in_ready}, 64'd1);

    // Flush in CALC, with a request presented at the same time
    start_op(0, 0, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check_val("flush_calc_in_ready", {63'd0, in_ready}, 64'd1);
    check_val("flush_calc_out_valid", {63'd0, out_valid}, 64'd0);
    repeat (40) begin
      @(posedge clk); #1;
      check_val("flush_calc_stays_idle", {62'd0, in_ready, out_valid}, 64'd2);
    end
    run_op(0, 0, 32'd9, 32'd3, 0);

    // Flush in DONE together with out_ready: not a handshake, result dropped
    start_op(0, 0, 32'd77, 32'd0);
    wait_valid(lat);
    check_val("flush_done_lat", 64'(lat), 64'd1);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    check_val("flush_done_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("flush_done_in_ready", {63'd0, in_ready}, 64'd1);
    run_op(0, 0, 32'd9, 32'd3, 0);

    // Asynchronous reset mid-CALC
    start_op(0, 0, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("areset_in_ready", {63'd0, in_ready}, 64'd1);
    check_val("areset_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("areset_result", {32'd0, result}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      check_val("areset_stays_idle", {62'd0, in_ready, out_valid}, 64'd2);
    end
    run_op(1, 0, -32'sd100, 32'd7, 0);

    check_val("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
